// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Programmable serial sequence-detection controller. A pattern configuration
// (bits, length, overlap mode, match limit) is accepted through a valid/ready
// handshake while IDLE. `start` arms a shift-compare detector on the gated
// serial stream (in_valid/inbits). Each match gives a one-cycle `detect`
// pulse. Optionally, matches are counted and the run stops after `cfg_max`
// matches.
//
// Optional feature macro: SEQDET_MATCH_COUNT_EN
//   defined   : match_count and cfg_max limiting (DONE state, `done` pulse)
//   undefined : match_count tied to 0, cfg_max ignored, DONE never entered
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   cfg_valid    in   configuration offer
//   cfg_ready    out  high in IDLE (registered)
//   cfg_pattern  in   PAT_W pattern, bit [len-1] arrives first, bit 0 last
//   cfg_len      in   pattern length, legal 1..PAT_W
//   cfg_overlap  in   1 = overlapping, 0 = non-overlapping detection
//   cfg_max      in   matches before auto-stop, 0 = unlimited
//   cfg_err      out  one-cycle pulse on an offer with illegal cfg_len
//   start        in   arm detector (IDLE only)
//   stop         in   abort run, return to IDLE (beats a same-cycle match)
//   in_valid     in   inbits sampled this cycle
//   inbits       in   serial data
//   detect       out  one-cycle match pulse, 1 cycle after the completing bit
//   done         out  one-cycle pulse, the cycle after the final detect
//   busy         out  high in RUN
//   match_count  out  matches in the current run (saturating)
//   dbg_state    out  FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a configuration transfers on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready depends only on the registered state,
// never combinationally on cfg_valid. An illegal cfg_len is still consumed
// (the offer completes) but only raises cfg_err; the stored config is kept.
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [4:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_max,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             inbits,
  output logic             detect,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] PAT_W_L = 5'(PAT_W);

  state_t           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [4:0]       r_len;
  logic             r_overlap;
  // Only the newest PAT_W-1 bits are kept; the incoming bit completes the
  // PAT_W-wide comparison window.
  logic [PAT_W-2:0] r_hist;
  logic [4:0]       r_bits_seen;
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic             r_detect;
  logic             r_done;
  logic             r_busy;

  logic             w_cfg_legal;
  logic [PAT_W-1:0] w_cand;
  logic [PAT_W-1:0] w_mask;
  logic             w_pat_hit;
  logic             w_len_ok;
  logic             w_match;
  logic [4:0]       w_bits_inc;
  logic             w_limit_hit;

  assign w_cfg_legal = (cfg_len != 5'd0) && (cfg_len <= PAT_W_L);
  assign w_cand      = {r_hist, inbits};

  // Only the low r_len bits of the window take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (5'(i) < r_len);
    end
  end

  assign w_pat_hit  = ((w_cand ^ r_pattern) & w_mask) == '0;
  // bits_seen counts bits since start (or since the last non-overlapping
  // match); the incoming bit adds one, so a full pattern needs len bits.
  assign w_len_ok   = ({1'b0, r_bits_seen} + 6'd1) >= {1'b0, r_len};
  assign w_match    = (r_state == ST_RUN) && in_valid && !stop && w_pat_hit && w_len_ok;
  assign w_bits_inc = (r_bits_seen == PAT_W_L) ? r_bits_seen : r_bits_seen + 5'd1;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] w_count_inc;

  assign w_count_inc = (&r_count) ? r_count : r_count + 1'b1;
  assign w_limit_hit = w_match && (r_max != '0) && (w_count_inc == r_max);
  assign match_count = r_count;
`else
  logic w_unused_max;

  assign w_unused_max = ^cfg_max;
  assign w_limit_hit  = 1'b0;
  assign match_count  = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_len       <= 5'd2;
      r_overlap   <= 1'b1;
      r_hist      <= '0;
      r_bits_seen <= 5'd0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_detect    <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SEQDET_MATCH_COUNT_EN
      r_count     <= '0;
      r_max       <= '0;
`endif
    end else begin
      r_cfg_err <= 1'b0;
      r_detect  <= 1'b0;
      r_done    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Config is latched before RUN begins, so a same-cycle start
          // runs with the new configuration.
          if (cfg_valid) begin
            if (w_cfg_legal) begin
              r_pattern <= cfg_pattern;
              r_len     <= cfg_len;
              r_overlap <= cfg_overlap;
`ifdef SEQDET_MATCH_COUNT_EN
              r_max     <= cfg_max;
`endif
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
          if (start) begin
            r_state     <= ST_RUN;
            r_hist      <= '0;
            r_bits_seen <= 5'd0;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef SEQDET_MATCH_COUNT_EN
            r_count     <= '0;
`endif
          end
        end

        ST_RUN: begin
          if (stop) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else if (in_valid) begin
            r_hist <= w_cand[PAT_W-2:0];
            if (w_match) begin
              r_detect    <= 1'b1;
              // Non-overlapping: restart the length qualification so no
              // bit of this match can be reused by the next one.
              r_bits_seen <= r_overlap ? w_bits_inc : 5'd0;
`ifdef SEQDET_MATCH_COUNT_EN
              r_count     <= w_count_inc;
`endif
              if (w_limit_hit) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bits_seen <= w_bits_inc;
            end
          end
        end

        ST_DONE: begin
          // One cycle here so `done` lands the cycle after the final detect.
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
          r_done      <= !stop;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign detect    = r_detect;
  assign done      = r_done;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [4:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_max;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic             in_valid;
  logic             inbits;
  logic             detect;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_max    (cfg_max),
    .cfg_err    (cfg_err),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .inbits     (inbits),
    .detect     (detect),
    .done       (done),
    .busy       (busy),
    .match_count(match_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // All drives happen 1 time unit after a rising edge; outputs are read at
  // the same point, i.e. reflecting the previous edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] pat, input logic [4:0] len,
                        input logic ovl, input logic [CNT_W-1:0] mx);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_max     = mx;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    inbits   = b;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  localparam logic [6:0] S2_BITS  = 7'b0111011;   // bits 1..7 MSB first
  localparam logic [6:0] S2_OVL   = 7'b0011001;   // detect after 3,4,7
  localparam logic [6:0] S2_NOVL  = 7'b0010001;   // detect after 3,7
  localparam logic [9:0] S4_BITS  = 10'b1011011011;
  localparam logic [9:0] S4_DET_C = 10'b0001001000; // limit 2 reached at bit 7
  localparam logic [9:0] S4_DET_N = 10'b0001001001; // unlimited
  localparam logic [9:0] S4_DONE  = 10'b0000000100; // done after bit 8's edge

  logic [6:0] s_bits, s_det;
  logic [9:0] l_bits, l_det, l_done;

  initial begin
    reset = 1'b0; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_max = '0; start = 0; stop = 0; in_valid = 0; inbits = 0;
    tick(); tick();
    check("rst_ready",  cfg_ready,   1);
    check("rst_err",    cfg_err,     0);
    check("rst_detect", detect,      0);
    check("rst_done",   done,        0);
    check("rst_busy",   busy,        0);
    check("rst_count",  match_count, 0);
    check("rst_state",  dbg_state,   0);
    reset = 1'b1;
    tick();

    // Reset mid-run with a partial match in history.
    do_cfg(8'h03, 5'd2, 1'b1, 8'd0);
    do_start();
    send_bit(1'b0);
    send_bit(1'b1);
    in_valid = 1'b1; inbits = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("mid_rst_busy",   busy,      0);
    check("mid_rst_ready",  cfg_ready, 1);
    check("mid_rst_detect", detect,    0);
    check("mid_rst_state",  dbg_state, 0);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("post_rst_detect", detect,    0);
    check("post_rst_ready",  cfg_ready, 1);

    // Pattern 11, overlapping.
    do_cfg(8'h03, 5'd2, 1'b1, 8'd0);
    do_start();
    check("run_busy",  busy,      1);
    check("run_ready", cfg_ready, 0);
    s_bits = S2_BITS; s_det = S2_OVL;
    for (int i = 6; i >= 0; i--) begin
      send_bit(s_bits[i]);
      check($sformatf("ovl_det_b%0d", 7 - i), detect, s_det[i]);
    end
    check("ovl_count", match_count, CNT_EN ? 3 : 0);
    do_stop();
    check("ovl_stop_state", dbg_state, 0);
    check("ovl_stop_busy",  busy,      0);

    // Same pattern, non-overlapping.
    do_cfg(8'h03, 5'd2, 1'b0, 8'd0);
    do_start();
    s_det = S2_NOVL;
    for (int i = 6; i >= 0; i--) begin
      send_bit(s_bits[i]);
      check($sformatf("novl_det_b%0d", 7 - i), detect, s_det[i]);
    end
    check("novl_count", match_count, CNT_EN ? 2 : 0);
    do_stop();

    // Pattern 1011, limit 2.
    do_cfg(8'h0B, 5'd4, 1'b1, 8'd2);
    do_start();
    l_bits = S4_BITS;
    l_det  = CNT_EN ? S4_DET_C : S4_DET_N;
    l_done = CNT_EN ? S4_DONE : 10'd0;
    for (int i = 9; i >= 0; i--) begin
      send_bit(l_bits[i]);
      check($sformatf("lim_det_b%0d", 10 - i),  detect, l_det[i]);
      check($sformatf("lim_done_b%0d", 10 - i), done,   l_done[i]);
    end
    check("lim_state", dbg_state,   CNT_EN ? 0 : 1);
    check("lim_count", match_count, CNT_EN ? 2 : 0);
    do_stop();

    // Illegal lengths leave the stored config alone.
    do_cfg(8'h03, 5'd2, 1'b1, 8'd0);
    check("legal_no_err", cfg_err, 0);
    do_cfg(8'h00, 5'd0, 1'b1, 8'd0);
    check("len0_err", cfg_err, 1);
    tick();
    check("len0_err_clear", cfg_err, 0);
    do_cfg(8'h00, 5'd9, 1'b1, 8'd0);
    check("len9_err", cfg_err, 1);
    do_start();
    send_bit(1'b0); check("err_det_b1", detect, 0);
    send_bit(1'b1); check("err_det_b2", detect, 0);
    send_bit(1'b1); check("err_det_b3", detect, 1);
    do_stop();

    // Stop on a completing bit, and start ignored while running.
    do_start();
    send_bit(1'b1); check("stp_det_b1", detect, 0);
    send_bit(1'b1); check("stp_det_b2", detect, 1);
    start = 1'b1;
    send_bit(1'b1);
    start = 1'b0;
    check("start_in_run_det",   detect,      1);
    check("start_in_run_state", dbg_state,   1);
    check("start_in_run_count", match_count, CNT_EN ? 2 : 0);
    in_valid = 1'b1; inbits = 1'b1; stop = 1'b1;
    tick();
    in_valid = 1'b0; stop = 1'b0;
    check("stop_det",   detect,      0);
    check("stop_count", match_count, CNT_EN ? 2 : 0);
    check("stop_state", dbg_state,   0);
    check("stop_ready", cfg_ready,   1);
    tick();
    check("stop_det_after", detect, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
